serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 109 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave is the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             io_start;
    logic [WIDTH-1:0] io_a;
    logic [WIDTH-1:0] io_b;
    logic             io_busy;
    logic             io_done;
    logic [WIDTH-1:0] io_c;
    logic             io_borrow;

    modport master (
        output io_start, io_a, io_b,
        input  io_busy, io_done, io_c, io_borrow
    );

    modport slave (
        input  io_start, io_a, io_b,
        output io_busy, io_done, io_c, io_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: c = (a - b) mod 2^WIDTH plus final borrow, one bit per cycle, LSB first.
// Latency: done pulses in the cycle after edge E0+WIDTH (start accepted at E0); start-to-start WIDTH+2 cycles.
// Backpressure: none; io_start is only sampled in IDLE and ignored while busy or done.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             borrow_q, borrow_d;

    logic             bit_a;
    logic             bit_b;
    logic             diff_bit;
    logic             bw_nxt;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor slice for the bit currently selected by the counter
    assign bit_a     = a_q[cnt_q];
    assign bit_b     = b_q[cnt_q];
    assign diff_bit  = bit_a ^ bit_b ^ bw_q;
    assign bw_nxt    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_q);
    assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        c_d      = c_q;
        borrow_d = borrow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.io_start) begin
                    a_d     = bus.io_a;
                    b_d     = bus.io_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_shift;
                bw_d  = bw_nxt;
                // Last bit: publish straight from the shifter so io_c lands on this edge
                if (cnt_q == CW'(WIDTH - 1)) begin
                    c_d      = res_shift;
                    borrow_d = bw_nxt;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            c_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            c_q      <= c_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.io_busy   = (state_q == RUN);
    assign bus.io_done   = (state_q == DONE);
    assign bus.io_c      = c_q;
    assign bus.io_borrow = borrow_q;
endmodule
